// File: rtl/btn_event_frontend.sv
// rtl/btn_event_frontend.sv - debounced 8-button front end with press-event FIFO
module btn_event_frontend #(
   parameter int DB_CYCLES  = 16,
   parameter int CNT_W      = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] btn,
   input  logic       enable,
   input  logic       ev_ready,
   input  logic       clear_overflow,
   output logic [7:0] btn_level,
   output logic [7:0] press_pulse,
   output logic       ev_valid,
   output logic [2:0] ev_idx,
   output logic [7:0] ev_stamp,
   output logic       ev_overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [7:0]       sync1, btn_s;
   logic [CNT_W-1:0] cnt [8];
   logic [7:0]       toggle, rise;

   logic [7:0]       pending, push_mask, new_press, ovf_hit;
   logic [2:0]       push_idx;
   logic [7:0]       stamp;
   logic             fifo_full, push, pop;
   logic [CW-1:0]    count;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [2:0]       mem_idx   [FIFO_DEPTH];
   logic [7:0]       mem_stamp [FIFO_DEPTH];

   always_comb begin
      toggle = '0;
      for (int i = 0; i < 8; i++)
         toggle[i] = (btn_s[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
      rise = toggle & ~btn_level;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1       <= '0;
         btn_s       <= '0;
         btn_level   <= '0;
         press_pulse <= '0;
         for (int i = 0; i < 8; i++)
            cnt[i] <= '0;
      end else begin
         sync1       <= btn;
         btn_s       <= sync1;
         btn_level   <= btn_level ^ toggle;
         press_pulse <= rise;
         for (int i = 0; i < 8; i++) begin
            if (btn_s[i] == btn_level[i] || toggle[i])
               cnt[i] <= '0;
            else
               cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   // Lowest pending index wins; a pop in the same cycle frees the slot for a full FIFO.
   always_comb begin
      pop       = ev_valid && ev_ready;
      fifo_full = (count == CW'(FIFO_DEPTH));
      push      = (pending != 8'd0) && (!fifo_full || pop);
      push_idx  = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (pending[i]) push_idx = 3'(i);
      push_mask = push ? (8'b1 << push_idx) : 8'b0;
      new_press = rise & {8{enable}};
      ovf_hit   = new_press & pending & ~push_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending     <= '0;
         ev_overflow <= 1'b0;
         stamp       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else begin
         stamp   <= stamp + 8'd1;
         pending <= (pending & ~push_mask) | new_press;
         if (ovf_hit != 8'd0)
            ev_overflow <= 1'b1;
         else if (clear_overflow)
            ev_overflow <= 1'b0;
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_idx[wr_ptr]   <= push_idx;
         mem_stamp[wr_ptr] <= stamp;
      end
   end

   assign ev_valid = (count != '0);
   assign ev_idx   = mem_idx[rd_ptr];
   assign ev_stamp = mem_stamp[rd_ptr];

endmodule

// File: tb/tb_btn_event_frontend.sv
// tb/tb_btn_event_frontend.sv - directed table-driven bench for btn_event_frontend
module tb_btn_event_frontend;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] btn;
   logic       enable;
   logic       ev_ready;
   logic       clear_overflow;
   logic [7:0] btn_level;
   logic [7:0] press_pulse;
   logic       ev_valid;
   logic [2:0] ev_idx;
   logic [7:0] ev_stamp;
   logic       ev_overflow;

   btn_event_frontend #(.DB_CYCLES(16), .CNT_W(5), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .btn            (btn),
      .enable         (enable),
      .ev_ready       (ev_ready),
      .clear_overflow (clear_overflow),
      .btn_level      (btn_level),
      .press_pulse    (press_pulse),
      .ev_valid       (ev_valid),
      .ev_idx         (ev_idx),
      .ev_stamp       (ev_stamp),
      .ev_overflow    (ev_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  btn;
      logic        en;
      logic [7:0]  exp_level;
      logic [7:0]  exp_pulse;
      int          exp_n;
      logic [23:0] exp_seq;
   } vec_t;

   vec_t vecs [5];

   int         checks = 0;
   int         errors = 0;
   int         cyc;
   int         pulse_cycles;
   int         pulse_first;
   logic [7:0] pulse_acc;
   int         ev_idx_q   [$];
   int         ev_stamp_q [$];
   int         ev_cyc_q   [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      pulse_cycles = 0;
      pulse_first  = -1;
      pulse_acc    = '0;
      ev_idx_q.delete();
      ev_stamp_q.delete();
      ev_cyc_q.delete();
   endtask

   // Record the current cycle, then advance across one rising edge.
   task automatic step();
      if (press_pulse != 8'd0) begin
         if (pulse_first < 0) pulse_first = cyc;
         pulse_cycles++;
         pulse_acc |= press_pulse;
      end
      if (ev_valid && ev_ready) begin
         ev_idx_q.push_back(int'(ev_idx));
         ev_stamp_q.push_back(int'(ev_stamp));
         ev_cyc_q.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      clear_logs();
   endtask

   task automatic build_overflow();
      btn = 8'h00;
      do_reset();
      enable   = 1'b1;
      ev_ready = 1'b0;
      btn = 8'h1F;
      repeat (25) step();
      chk("ovf_pre_valid", ev_valid, 1);
      chk("ovf_pre_head", ev_idx, 0);
      chk("ovf_pre_flag", ev_overflow, 0);
      btn = 8'h0F;
      repeat (22) step();
      btn = 8'h1F;
      repeat (22) step();
      chk("ovf_flag_set", ev_overflow, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h08, 1'b1, 8'h08, 8'h08, 1, 24'o3};
      vecs[1] = '{8'h62, 1'b1, 8'h62, 8'h62, 3, 24'o651};
      vecs[2] = '{8'h04, 1'b0, 8'h04, 8'h04, 0, 24'o0};
      vecs[3] = '{8'hFF, 1'b1, 8'hFF, 8'hFF, 8, 24'o76543210};
      vecs[4] = '{8'h81, 1'b1, 8'h81, 8'h81, 2, 24'o70};

      btn = 8'h04;
      enable = 1'b1;
      ev_ready = 1'b1;
      clear_overflow = 1'b0;
      cyc = 0;
      do_reset();
      chk("rst_level", btn_level, 0);
      chk("rst_pulse", press_pulse, 0);
      chk("rst_valid", ev_valid, 0);
      chk("rst_ovf", ev_overflow, 0);
      repeat (30) step();
      chk("held_pulse_cycles", pulse_cycles, 1);
      chk("held_pulse_first", pulse_first, 18);
      chk("held_events", ev_idx_q.size(), 1);
      if (ev_idx_q.size() == 1) chk("held_idx", ev_idx_q[0], 2);

      for (int v = 0; v < 5; v++) begin
         btn = 8'h00;
         do_reset();
         enable   = vecs[v].en;
         ev_ready = 1'b1;
         btn      = vecs[v].btn;
         repeat (45) step();
         chk($sformatf("v%0d_level", v), btn_level, vecs[v].exp_level);
         chk($sformatf("v%0d_pulse", v), pulse_acc, vecs[v].exp_pulse);
         chk($sformatf("v%0d_pulse_cycles", v), pulse_cycles, 1);
         chk($sformatf("v%0d_pulse_first", v), pulse_first, 18);
         chk($sformatf("v%0d_events", v), ev_idx_q.size(), vecs[v].exp_n);
         if (ev_idx_q.size() == vecs[v].exp_n) begin
            for (int k = 0; k < vecs[v].exp_n; k++) begin
               chk($sformatf("v%0d_idx%0d", v, k), ev_idx_q[k], vecs[v].exp_seq[3*k +: 3]);
               chk($sformatf("v%0d_cyc%0d", v, k), ev_cyc_q[k], 19 + k);
               chk($sformatf("v%0d_stamp%0d", v, k), ev_stamp_q[k], 18 + k);
            end
         end
         btn = 8'h00;
         clear_logs();
         repeat (25) step();
         chk($sformatf("v%0d_rel_level", v), btn_level, 0);
         chk($sformatf("v%0d_rel_pulse", v), pulse_acc, 0);
         chk($sformatf("v%0d_rel_events", v), ev_idx_q.size(), 0);
      end

      btn = 8'h00;
      do_reset();
      enable   = 1'b1;
      ev_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         btn[0] = ((k / 5) % 2) == 0;
         step();
      end
      btn = 8'h00;
      repeat (25) step();
      chk("glitch_pulse", pulse_acc, 0);
      chk("glitch_events", ev_idx_q.size(), 0);
      chk("glitch_level", btn_level, 0);

      btn = 8'h00;
      do_reset();
      btn = 8'h02;
      repeat (15) step();
      btn = 8'h00;
      repeat (25) step();
      chk("short15_pulse", pulse_acc, 0);
      chk("short15_level", btn_level, 0);
      chk("short15_events", ev_idx_q.size(), 0);
      btn = 8'h02;
      repeat (16) step();
      btn = 8'h00;
      repeat (40) step();
      chk("exact16_pulse", pulse_acc, 8'h02);
      chk("exact16_pulse_cycles", pulse_cycles, 1);
      chk("exact16_events", ev_idx_q.size(), 1);
      chk("exact16_level_back", btn_level, 0);

      build_overflow();
      enable   = 1'b0;
      ev_ready = 1'b1;
      clear_logs();
      repeat (10) step();
      chk("drain_events", ev_idx_q.size(), 5);
      if (ev_idx_q.size() == 5) begin
         for (int k = 0; k < 5; k++) begin
            chk($sformatf("drain_idx%0d", k), ev_idx_q[k], k);
            chk($sformatf("drain_cyc%0d", k), ev_cyc_q[k] - ev_cyc_q[0], k);
         end
      end
      chk("drain_valid_end", ev_valid, 0);
      chk("drain_ovf_sticky", ev_overflow, 1);
      clear_overflow = 1'b1;
      step();
      clear_overflow = 1'b0;
      chk("ovf_cleared", ev_overflow, 0);

      build_overflow();
      chk("rst_mid_valid_pre", ev_valid, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_valid", ev_valid, 0);
      chk("rst_mid_ovf", ev_overflow, 0);
      chk("rst_mid_level", btn_level, 0);
      chk("rst_mid_pulse", press_pulse, 0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
